// File: rtl/endscene_ctrl.sv
// End-of-game scene controller: draws a blinking bitmap text window once the
// game ends, holds it for a minimum number of frames, then waits for a key
// and emits a single-cycle restart pulse.
module endscene_ctrl #(
  parameter int unsigned X0           = 240,
  parameter int unsigned Y0           = 176,
  parameter int unsigned SCALE_SH     = 2,
  parameter int unsigned BLINK_FRAMES = 30,  // must be <= 63
  parameter int unsigned HOLD_FRAMES  = 60   // must be <= 127
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        game_over,
  input  logic        key_any,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [4:0]  rom_addr,
  input  logic [39:0] rom_data,
  output logic        text_on,
  output logic        scene_active,
  output logic        restart
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShow  = 2'd1;
  localparam logic [1:0] StArmed = 2'd2;
  localparam logic [1:0] StExit  = 2'd3;

  // Window bounds kept in 32-bit unsigned so the compare never wraps.
  localparam int unsigned X1 = X0 + (32'd40 << SCALE_SH);
  localparam int unsigned Y1 = Y0 + (32'd32 << SCALE_SH);
  localparam logic [9:0]  X0W = 10'(X0);
  localparam logic [9:0]  Y0W = 10'(Y0);

  localparam logic [6:0] HoldLast  = 7'(HOLD_FRAMES - 1);
  localparam logic [5:0] BlinkLast = 6'(BLINK_FRAMES - 1);

  logic       fclk_meta_q, fclk_sync_q, fclk_prev_q;
  logic       frame_tick;
  logic       game_over_q;
  logic       go_armed_q, go_armed_d;
  logic       go_edge;
  logic [1:0] state_q, state_d;
  logic [6:0] hold_q, hold_d;
  logic [5:0] blink_q, blink_d;
  logic       visible_q, visible_d;
  logic       text_on_q, text_on_d;
  logic       active_q, active_d;
  logic       restart_q, restart_d;

  logic       in_win;
  logic [9:0] dx, dy;
  logic [5:0] col;
  logic [4:0] row;
  logic [5:0] bit_idx;
  logic       pix_bit;

  // Frame tick from the synchronized vsync rising edge; game_over edge detect.
  // go_armed_q only sets once game_over has been seen low, so a level that is
  // already high when reset releases cannot start a scene.
  always_comb begin
    frame_tick = fclk_sync_q & ~fclk_prev_q;
    go_armed_d = go_armed_q | ~game_over;
    go_edge    = game_over & ~game_over_q & go_armed_q;
  end

  // Text window decode and bitmap lookup.
  always_comb begin
    in_win   = (32'(DrawX) >= X0) && (32'(DrawX) < X1) &&
               (32'(DrawY) >= Y0) && (32'(DrawY) < Y1);
    dx       = DrawX - X0W;
    dy       = DrawY - Y0W;
    col      = 6'(dx >> SCALE_SH);
    row      = 5'(dy >> SCALE_SH);
    rom_addr = in_win ? row : 5'd0;
    bit_idx  = in_win ? (6'd39 - col) : 6'd0;
    pix_bit  = in_win & rom_data[bit_idx];
  end

  // Scene FSM, hold and blink counters, next-state of registered outputs.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    blink_d   = blink_q;
    visible_d = visible_q;
    unique case (state_q)
      StIdle: begin
        if (go_edge) begin
          state_d   = StShow;
          hold_d    = 7'd0;
          blink_d   = 6'd0;
          visible_d = 1'b1;
        end
      end
      StShow: begin
        if (frame_tick) begin
          hold_d = hold_q + 7'd1;
          if (hold_q == HoldLast) state_d = StArmed;
          if (blink_q == BlinkLast) begin
            blink_d   = 6'd0;
            visible_d = ~visible_q;
          end else begin
            blink_d = blink_q + 6'd1;
          end
        end
      end
      StArmed: begin
        // A key press wins over a coincident tick; the blink state is frozen.
        if (key_any) begin
          state_d   = StExit;
          visible_d = 1'b0;
        end else if (frame_tick) begin
          if (blink_q == BlinkLast) begin
            blink_d   = 6'd0;
            visible_d = ~visible_q;
          end else begin
            blink_d = blink_q + 6'd1;
          end
        end
      end
      StExit: begin
        state_d   = StIdle;
        visible_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    active_d  = (state_d == StShow) || (state_d == StArmed);
    restart_d = (state_d == StExit);
    text_on_d = pix_bit & visible_q & ((state_q == StShow) || (state_q == StArmed));
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fclk_meta_q <= 1'b0;
      fclk_sync_q <= 1'b0;
      fclk_prev_q <= 1'b0;
      game_over_q <= 1'b0;
      go_armed_q  <= 1'b0;
      state_q     <= StIdle;
      hold_q      <= 7'd0;
      blink_q     <= 6'd0;
      visible_q   <= 1'b0;
      text_on_q   <= 1'b0;
      active_q    <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      fclk_meta_q <= frame_clk;
      fclk_sync_q <= fclk_meta_q;
      fclk_prev_q <= fclk_sync_q;
      game_over_q <= game_over;
      go_armed_q  <= go_armed_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      visible_q   <= visible_d;
      text_on_q   <= text_on_d;
      active_q    <= active_d;
      restart_q   <= restart_d;
    end
  end

  assign text_on      = text_on_q;
  assign scene_active = active_q;
  assign restart      = restart_q;

endmodule

// File: tb/tb_endscene_ctrl.sv
// Directed bench for endscene_ctrl with a combinational bitmap ROM model and
// a queue of expected text_on values checked one cycle after each pixel.
module tb_endscene_ctrl;

  logic        Clk, Reset, frame_clk, game_over, key_any;
  logic [9:0]  DrawX, DrawY;
  logic [4:0]  rom_addr;
  logic [39:0] rom_data;
  logic        text_on, scene_active, restart;

  int n_vec = 0;
  int n_err = 0;

  int model_active = 0;
  int model_ticks  = 0;

  logic  exp_q[$];
  string tag_q[$];

  endscene_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .game_over    (game_over),
    .key_any      (key_any),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .text_on      (text_on),
    .scene_active (scene_active),
    .restart      (restart)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic pix(input int r, input int c);
    return ((r + c) % 3) == 1;
  endfunction

  // Bitmap ROM: bit 39 is column 0.
  always_comb begin
    rom_data = '0;
    for (int c = 0; c < 40; c++) rom_data[39 - c] = pix(int'(rom_addr), c);
  end

  function automatic logic inwin(input int x, input int y);
    return (x >= 240) && (x < 400) && (y >= 176) && (y < 304);
  endfunction

  function automatic logic [4:0] exp_addr(input int x, input int y);
    if (!inwin(x, y)) return 5'd0;
    return 5'((y - 176) / 4);
  endfunction

  function automatic logic exp_text(input int x, input int y);
    if (model_active == 0 || !inwin(x, y)) return 1'b0;
    return pix((y - 176) / 4, (x - 240) / 4) && (((model_ticks / 30) % 2) == 0);
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a pixel, check the combinational address, then check text_on next cycle.
  task automatic pixel(input string tag, input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    check({tag, ".addr"}, 40'(rom_addr), 40'(exp_addr(x, y)));
    exp_q.push_back(exp_text(x, y));
    tag_q.push_back({tag, ".text"});
    @(posedge Clk);
    #1;
    begin
      logic  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 40'(text_on), 40'(e));
    end
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    if (model_active != 0) model_ticks++;
  endtask

  task automatic start_scene(input string tag);
    game_over = 1'b0;
    repeat (2) @(posedge Clk);
    #1 game_over = 1'b1;
    @(posedge Clk);
    #1;
    model_active = 1;
    model_ticks  = 0;
    check(tag, 40'(scene_active), 40'd1);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; game_over = 1'b0; key_any = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst.text_on", 40'(text_on), 40'd0);
    check("rst.active", 40'(scene_active), 40'd0);
    check("rst.restart", 40'(restart), 40'd0);
    check("rst.addr", 40'(rom_addr), 40'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Scene 1: window decode and blinking.
    start_scene("s1.enter");
    pixel("s1.p260", 260, 184);
    pixel("s1.p256", 256, 184);
    pixel("s1.p239", 239, 184);
    pixel("s1.p400", 400, 184);
    pixel("s1.y304", 260, 304);
    pixel("s1.corner", 399, 303);
    pixel("s1.p300", 300, 303);
    repeat (29) frame_pulse();
    pixel("s1.t29", 260, 184);
    frame_pulse();
    pixel("s1.t30", 260, 184);
    repeat (30) frame_pulse();
    pixel("s1.t60", 260, 184);
    check("s1.armed", 40'(scene_active), 40'd1);

    // Key and tick arrive in the same cycle while armed.
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 key_any = 1'b1;
    @(posedge Clk);
    #1;
    model_active = 0;
    check("s1.exit.restart", 40'(restart), 40'd1);
    check("s1.exit.active", 40'(scene_active), 40'd0);
    @(posedge Clk);
    #1;
    check("s1.idle.restart", 40'(restart), 40'd0);
    frame_clk = 1'b0;
    key_any   = 1'b0;
    pixel("s1.idle", 260, 184);
    repeat (5) @(posedge Clk);
    #1;
    check("s1.noretrig", 40'(scene_active), 40'd0);

    // Scene 2: key held from entry is ignored until the hold expires.
    key_any = 1'b1;
    start_scene("s2.enter");
    repeat (59) frame_pulse();
    check("s2.t59.active", 40'(scene_active), 40'd1);
    check("s2.t59.restart", 40'(restart), 40'd0);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("s2.armed.active", 40'(scene_active), 40'd1);
    check("s2.armed.restart", 40'(restart), 40'd0);
    @(posedge Clk);
    #1;
    model_active = 0;
    check("s2.exit.restart", 40'(restart), 40'd1);
    @(posedge Clk);
    #1;
    check("s2.idle.restart", 40'(restart), 40'd0);
    check("s2.idle.active", 40'(scene_active), 40'd0);
    frame_clk = 1'b0;
    key_any   = 1'b0;

    // Scene 3: reset mid-scene aborts without restart and needs a new edge.
    start_scene("s3.enter");
    repeat (5) frame_pulse();
    pixel("s3.text", 260, 184);
    #2 Reset = 1'b1;
    #1;
    model_active = 0;
    check("s3.rst.text_on", 40'(text_on), 40'd0);
    check("s3.rst.active", 40'(scene_active), 40'd0);
    check("s3.rst.restart", 40'(restart), 40'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    begin
      logic seen_restart, seen_active;
      seen_restart = 1'b0;
      seen_active  = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge Clk);
        #1;
        seen_restart |= restart;
        seen_active  |= scene_active;
      end
      check("s3.held.restart", 40'(seen_restart), 40'd0);
      check("s3.held.active", 40'(seen_active), 40'd0);
    end
    start_scene("s3.reenter");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/endscene_ctrl.md
ENDSCENE_CTRL -- requirements
Module: endscene_ctrl

Interface
REQ-001 Parameter X0, default 240: left pixel column of the text window.
REQ-002 Parameter Y0, default 176: top pixel row of the text window.
REQ-003 Parameter SCALE_SH, default 2: each bitmap bit is drawn as a (1<<SCALE_SH)-pixel square, giving a 160x128 window at default.
REQ-004 Parameter BLINK_FRAMES, default 30: frames per visibility half-period.
REQ-005 Parameter HOLD_FRAMES, default 60: frames before key input is accepted.
REQ-006 Clk  in  1  system clock; all state on rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 frame_clk  in  1  VGA vertical-sync level, asynchronous to Clk.
REQ-009 game_over  in  1  level from game logic; a rising edge starts the scene.
REQ-010 key_any  in  1  high while any keyboard key is pressed.
REQ-011 DrawX  in  10  current VGA pixel column.
REQ-012 DrawY  in  10  current VGA pixel row.
REQ-013 rom_addr  out  5  row address to the 32x40 end-scene bitmap ROM, whose data is combinational.
REQ-014 rom_data  in  40  bitmap row; bit 39 is column 0 (leftmost).
REQ-015 text_on  out  1  registered; the pixel belongs to visible text.
REQ-016 scene_active  out  1  registered; high in SHOW and ARMED.
REQ-017 restart  out  1  registered single-cycle pulse requesting a game restart.

Function
REQ-018 frame_clk SHALL pass through a 2-flop synchronizer; a rising edge on the synchronized signal SHALL produce a 1-cycle frame_tick.
REQ-019 game_over SHALL be registered, and go_edge = game_over & ~game_over_q.
REQ-020 in_win = (X0 <= DrawX < X0+(40<<SCALE_SH)) & (Y0 <= DrawY < Y0+(32<<SCALE_SH)), computed in unsigned arithmetic with no wrap-around.
REQ-021 row = (DrawY-Y0)>>SCALE_SH truncated to 5 bits and col = (DrawX-X0)>>SCALE_SH (0..39); rom_addr = row when in_win, else 0 (combinational).
REQ-022 text_on SHALL be registered: text_on <= in_win & rom_data[39-col] & visible & scene_state; latency is exactly 1 Clk from DrawX/DrawY.
REQ-023 FSM states are IDLE, SHOW, ARMED and EXIT.
REQ-024 IDLE transitions to SHOW on go_edge; on entry hold_cnt=0, blink_cnt=0 and visible=1.
REQ-025 SHOW: on each frame_tick, hold_cnt increments; when hold_cnt reaches HOLD_FRAMES-1 on a tick, go to ARMED. key_any is ignored in SHOW.
REQ-026 ARMED: key_any=1 transitions to EXIT; key_any takes priority over a simultaneous frame_tick.
REQ-027 EXIT: restart=1 for exactly that cycle, then IDLE unconditionally; visible is forced to 0.
REQ-028 Blink in SHOW/ARMED: on frame_tick, blink_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and visible toggles.
REQ-029 go_edge outside IDLE is ignored; a held-high game_over SHALL NOT re-trigger after EXIT.
REQ-030 In IDLE and EXIT, text_on=0 regardless of DrawX/DrawY.
REQ-031 Counters: hold_cnt 7 bits and blink_cnt 6 bits; parameters SHALL fit these widths (HOLD_FRAMES<=127, BLINK_FRAMES<=63).

Reset
REQ-032 Reset SHALL force IDLE, text_on=0, scene_active=0, restart=0, visible=0, all counters to 0, game_over_q=0 and the synchronizer flops to 0, immediately and asynchronously.
REQ-033 Reset asserted mid-scene SHALL abort without a restart pulse; after release a new game_over rising edge is required.

Verification
REQ-034 Reset, game_over 0->1, DrawY=184, DrawX=260 -> rom_addr=2; next cycle text_on=1 (row 2, col 5 bit=1); DrawX=256 (col 4) -> text_on=0.
REQ-035 DrawX=239 or DrawX=400 with DrawY=184 -> rom_addr=0 and text_on=0; DrawY=304 -> outside the window, text_on=0.
REQ-036 In SHOW, 30 frame_clk pulses -> visible toggles to 0 and text_on=0 at in-text pixels; 30 more pulses -> visible returns to 1.
REQ-037 key_any=1 held from entry: stays SHOW until the 60th frame_tick, then ARMED -> EXIT -> restart high for exactly 1 cycle -> IDLE with scene_active=0.
REQ-038 In ARMED, key_any and frame_tick in the same cycle -> EXIT; blink_cnt is not updated.
REQ-039 Reset pulse during SHOW -> all outputs 0 at once, restart never asserted; game_over held high afterwards -> stays IDLE until a 0->1 transition.
